// File: rtl/fp16_result_collector_if.sv
// Bundles the adder result input, the ready/valid result output and the status outputs of the collector.
// master drives the adder side and consumer ready; slave is the collector itself.
interface fp16_result_collector_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic [15:0]      in_result;
   logic [3:0]       in_flags;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_result;
   logic [3:0]       out_flags;
   logic [LW-1:0]    level;
   logic             full;
   logic             empty;
   logic [3:0]       sticky_flags;
   logic             drop;
   logic             sticky_clear;
   logic [CNT_W-1:0] result_count;

   modport master (
      output in_valid, in_result, in_flags, out_ready, sticky_clear,
      input  out_valid, out_result, out_flags, level, full, empty,
             sticky_flags, drop, result_count
   );

   modport slave (
      input  in_valid, in_result, in_flags, out_ready, sticky_clear,
      output out_valid, out_result, out_flags, level, full, empty,
             sticky_flags, drop, result_count
   );
endinterface

// File: rtl/fp16_result_collector.sv
// Buffers FP16 adder results in a FWFT FIFO (write-to-head latency 1 cycle, no empty bypass) and re-issues them
// on ready/valid; inputs arriving while full without a same-cycle pop are dropped and flagged sticky.
module fp16_result_collector #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   fp16_result_collector_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [15:0] result;
      logic [3:0]  flags;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [3:0]       sticky_q, sticky_d;
   logic             drop_q, drop_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic full, empty, pop, push_ok, overrun;
   logic [3:0] in_evt_flags;
   entry_t head;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign pop     = !empty && bus.out_ready;
   assign push_ok = bus.in_valid && (!full || pop);
   assign overrun = bus.in_valid && full && !pop;
   assign in_evt_flags = bus.in_valid ? bus.in_flags : 4'b0000;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      sticky_d = sticky_q;
      drop_d   = drop_q;
      cnt_d    = cnt_q;

      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push_ok, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // A same-cycle event outranks the clear so it is never lost.
      if (bus.sticky_clear) begin
         sticky_d = in_evt_flags;
         drop_d   = overrun;
      end else begin
         sticky_d = sticky_q | in_evt_flags;
         drop_d   = drop_q | overrun;
      end

      if (push_ok && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         sticky_q <= '0;
         drop_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         sticky_q <= sticky_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem_q[wr_ptr_q] <= '{result: bus.in_result, flags: bus.in_flags};
   end

   assign head             = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.out_valid    = !empty;
   assign bus.out_result   = head.result;
   assign bus.out_flags    = head.flags;
   assign bus.level        = level_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.sticky_flags = sticky_q;
   assign bus.drop         = drop_q;
   assign bus.result_count = cnt_q;
endmodule

// File: tb/tb_fp16_result_collector.sv
// Directed bench: FIFO ordering, overrun/drop, sticky clear priority, counter saturation and mid-stream reset.
module tb_fp16_result_collector;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   fp16_result_collector_if #(.DEPTH(8), .CNT_W(16)) bus_a ();
   fp16_result_collector_if #(.DEPTH(8), .CNT_W(3))  bus_b ();

   fp16_result_collector #(.DEPTH(8), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   fp16_result_collector #(.DEPTH(8), .CNT_W(3))  dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_a.in_valid = 0; bus_a.in_result = '0; bus_a.in_flags = '0;
      bus_a.out_ready = 0; bus_a.sticky_clear = 0;
      bus_b.in_valid = 0; bus_b.in_result = '0; bus_b.in_flags = '0;
      bus_b.out_ready = 0; bus_b.sticky_clear = 0;
   endtask

   task automatic reset_a();
      idle_inputs();
      rst_a = 1; tick(); tick(); rst_a = 0;
   endtask

   task automatic write_a(input logic [15:0] r, input logic [3:0] f);
      bus_a.in_valid = 1; bus_a.in_result = r; bus_a.in_flags = f;
      tick();
      bus_a.in_valid = 0; bus_a.in_flags = '0;
   endtask

   initial begin
      logic [15:0] exp_r;
      rst_a = 1; rst_b = 1;
      idle_inputs();
      tick(); tick();
      rst_a = 0; rst_b = 0;

      // reset state, then out_ready while empty
      check_eq("rst_out_valid", 32'(bus_a.out_valid), 0);
      check_eq("rst_level", 32'(bus_a.level), 0);
      check_eq("rst_empty", 32'(bus_a.empty), 1);
      check_eq("rst_full", 32'(bus_a.full), 0);
      check_eq("rst_sticky", 32'(bus_a.sticky_flags), 0);
      check_eq("rst_drop", 32'(bus_a.drop), 0);
      check_eq("rst_count", 32'(bus_a.result_count), 0);
      check_eq("rst_out_result", 32'(bus_a.out_result), 0);
      bus_a.out_ready = 1;
      for (int i = 0; i < 5; i++) tick();
      check_eq("idle_ready_level", 32'(bus_a.level), 0);
      check_eq("idle_ready_valid", 32'(bus_a.out_valid), 0);
      check_eq("idle_ready_count", 32'(bus_a.result_count), 0);

      // single write, one-cycle latency, then pop
      bus_a.out_ready = 0;
      write_a(16'hc0ae, 4'b0000);
      check_eq("one_valid", 32'(bus_a.out_valid), 1);
      check_eq("one_result", 32'(bus_a.out_result), 32'h0000c0ae);
      check_eq("one_level", 32'(bus_a.level), 1);
      tick();
      check_eq("one_hold", 32'(bus_a.out_result), 32'h0000c0ae);
      bus_a.out_ready = 1;
      tick();
      bus_a.out_ready = 0;
      check_eq("one_pop_valid", 32'(bus_a.out_valid), 0);
      check_eq("one_pop_level", 32'(bus_a.level), 0);
      check_eq("one_pop_count", 32'(bus_a.result_count), 1);

      // fill to full, then overrun
      reset_a();
      for (int i = 1; i <= 8; i++) write_a(16'(i), 4'b0000);
      check_eq("fill_full", 32'(bus_a.full), 1);
      check_eq("fill_drop_before", 32'(bus_a.drop), 0);
      write_a(16'h7c00, 4'b1000);
      check_eq("ovr_full", 32'(bus_a.full), 1);
      check_eq("ovr_level", 32'(bus_a.level), 8);
      check_eq("ovr_drop", 32'(bus_a.drop), 1);
      check_eq("ovr_sticky", 32'(bus_a.sticky_flags), 32'b1000);
      check_eq("ovr_count", 32'(bus_a.result_count), 8);
      check_eq("ovr_head", 32'(bus_a.out_result), 1);

      bus_a.sticky_clear = 1; tick(); bus_a.sticky_clear = 0;
      check_eq("clr_drop", 32'(bus_a.drop), 0);
      check_eq("clr_sticky", 32'(bus_a.sticky_flags), 0);

      // push while full with a same-cycle pop
      bus_a.in_valid = 1; bus_a.in_result = 16'h5060; bus_a.out_ready = 1;
      tick();
      bus_a.in_valid = 0;
      check_eq("fpp_level", 32'(bus_a.level), 8);
      check_eq("fpp_drop", 32'(bus_a.drop), 0);
      check_eq("fpp_count", 32'(bus_a.result_count), 9);
      for (int i = 0; i < 8; i++) begin
         exp_r = (i < 7) ? 16'(i + 2) : 16'h5060;
         check_eq("drain_valid", 32'(bus_a.out_valid), 1);
         check_eq("drain_result", 32'(bus_a.out_result), 32'(exp_r));
         tick();
      end
      bus_a.out_ready = 0;
      check_eq("drain_empty", 32'(bus_a.empty), 1);
      check_eq("drain_out_result", 32'(bus_a.out_result), 0);

      // sticky_clear colliding with a new flag event
      reset_a();
      for (int i = 0; i < 8; i++) write_a(16'h1000 + 16'(i), (i == 0) ? 4'b1001 : 4'b0000);
      write_a(16'h2000, 4'b0001);
      check_eq("sc_pre_sticky", 32'(bus_a.sticky_flags), 32'b1001);
      check_eq("sc_pre_drop", 32'(bus_a.drop), 1);
      check_eq("sc_pre_flags_head", 32'(bus_a.out_flags), 32'b1001);
      bus_a.in_valid = 1; bus_a.in_result = 16'h3c00; bus_a.in_flags = 4'b0010;
      bus_a.sticky_clear = 1; bus_a.out_ready = 1;
      tick();
      idle_inputs();
      check_eq("sc_sticky", 32'(bus_a.sticky_flags), 32'b0010);
      check_eq("sc_drop", 32'(bus_a.drop), 0);
      check_eq("sc_level", 32'(bus_a.level), 8);
      check_eq("sc_head", 32'(bus_a.out_result), 32'h1001);

      // counter saturation on the narrow-counter instance
      rst_b = 1; tick(); rst_b = 0;
      bus_b.out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         bus_b.in_valid = 1; bus_b.in_result = 16'h0100 + 16'(i);
         tick();
         check_eq("sat_head", 32'(bus_b.out_result), 32'h0100 + 32'(i));
      end
      check_eq("sat_count", 32'(bus_b.result_count), 7);
      check_eq("sat_level", 32'(bus_b.level), 1);
      bus_b.out_ready = 0; bus_b.in_result = 16'h0200;
      tick();
      check_eq("pre_rst_level", 32'(bus_b.level), 2);
      check_eq("pre_rst_count", 32'(bus_b.result_count), 7);
      rst_b = 1; bus_b.in_result = 16'h0300;
      tick();
      rst_b = 0; bus_b.in_valid = 0;
      check_eq("mid_rst_level", 32'(bus_b.level), 0);
      check_eq("mid_rst_valid", 32'(bus_b.out_valid), 0);
      check_eq("mid_rst_count", 32'(bus_b.result_count), 0);
      check_eq("mid_rst_result", 32'(bus_b.out_result), 0);
      tick();
      check_eq("post_rst_level", 32'(bus_b.level), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fp16_result_collector.md
Name: fp16_result_collector

Overview:
- Downstream stage of the pipelined FP16 adder. Consumes its per-cycle result and flag outputs.
- The adder has no backpressure, so this block buffers results in a small first-word-fall-through (FWFT) FIFO and re-issues them on a ready/valid interface.
- Also keeps sticky exception status, an overrun (drop) indicator and a saturating count of accepted results for the host/status logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  adder valid_out; one result per asserted cycle.
- in_result  input  16  adder FP16 result.
- in_flags  input  4  {overflow, zero, NaN, precisionLost} from adder.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer ready.
- out_result  output  16  FIFO head result.
- out_flags  output  4  FIFO head flags, same bit order as in_flags.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- sticky_flags  output  4  OR of in_flags over all in_valid cycles since last clear.
- drop  output  1  sticky: a valid input was lost because the FIFO was full.
- sticky_clear  input  1  clears sticky_flags and drop.
- result_count  output  CNT_W  number of accepted writes, saturating.

Behaviour:
- Reset: when rst is high at a clock edge, clear all state: level=0, empty=1, full=0, out_valid=0, sticky_flags=0, drop=0, result_count=0, pointers=0. out_result/out_flags = 0 while empty. Reset mid-stream discards all buffered entries, with no output handshake.
- pop = out_valid && out_ready.
- push_ok = in_valid && (!full || pop). Writing while full is allowed when the same cycle pops.
- FIFO storage is an array of {result, flags}.
  - Write pointer advances on push_ok; read pointer advances on pop.
  - Pointers wrap modulo DEPTH.
  - level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an entry written at edge N has out_valid=1 and its data on out_result/out_flags in the cycle after edge N. Empty-FIFO bypass in the same cycle is not allowed.
- out_valid = !empty. Head data holds stable while out_valid && !out_ready.
- Simultaneous push and pop when level==1: the old head leaves and the new entry becomes head at the next cycle; out_valid stays 1.
- Overrun: in_valid && full && !pop.
  - Input is discarded and drop sets to 1 next cycle.
  - FIFO contents and level are unchanged.
- sticky_flags |= in_flags on every in_valid cycle, whether the input is accepted or dropped.
- sticky_clear:
  - Clears sticky_flags and drop next cycle.
  - If the same cycle has an event (in_valid flags or an overrun), the event wins: the new bits are set, everything else is cleared.
- result_count increments on push_ok and holds at 2^CNT_W-1 (no wrap). sticky_clear does not affect it; only rst does.
- out_ready while empty has no effect.
- in_valid while rst is high is ignored.

Test Plan:
- Reset then idle → out_valid=0, level=0, empty=1, sticky_flags=0, drop=0, result_count=0; hold out_ready=1 for 5 cycles → no change.
- One write in_result=16'hc0ae, in_flags=4'b0000, out_ready=0 → after the next edge: out_valid=1, out_result=16'hc0ae, level=1; raise out_ready → after 1 edge: out_valid=0, level=0, result_count=1.
- DEPTH=8, out_ready=0, write 16'h0001..16'h0008, then a 9th write 16'h7c00 with flags 4'b1000 → full=1, level=8, drop=1, sticky_flags[3]=1, result_count=8. Drain → 0001..0008 in order; 7c00 is absent.
- At full, same-cycle in_valid (16'h5060) and out_ready=1 → level stays 8, drop stays 0, 16'h5060 is emitted last after draining.
- sticky_clear=1 in the same cycle as in_valid with flags 4'b0010 (NaN), prior sticky=4'b1001, drop=1 → next cycle sticky_flags=4'b0010, drop=0.
- CNT_W=3, 10 accepted writes with continuous out_ready=1 → result_count saturates at 7. Then rst mid-stream with level=2 → next cycle level=0, out_valid=0, result_count=0.
